// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Purpose  : LC-3 write-back stage. Picks the write-back value from the
//            execute and memory results, writes it into the 8 x 16 register
//            file, updates the {N,Z,P} condition codes, and serves the two
//            combinational operand reads used by execute.
// Ports    : clock            - system clock, all state changes on posedge
//            reset            - synchronous active-high reset; wins over writes
//            enable_writeback - stage enable; nothing changes while low
//            W_Control[1:0]   - 00 aluout, 01 pcout, 10 memout, 11 no write
//            aluout/pcout/memout[15:0] - candidate write-back values
//            dr[2:0]          - destination register index
//            sr1/sr2[2:0]     - read port indices
//            VSR1/VSR2[15:0]  - read port data
//            psr[2:0]         - condition codes {N,Z,P}
// Options  : `define WB_BYPASS_EN forwards the value being written to a read
//            port whose index matches dr in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_writeback,
    input  logic [1:0]        W_Control,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] pcout,
    input  logic [DATA_W-1:0] memout,
    input  logic [2:0]        dr,
    input  logic [2:0]        sr1,
    input  logic [2:0]        sr2,
    output logic [DATA_W-1:0] VSR1,
    output logic [DATA_W-1:0] VSR2,
    output logic [2:0]        psr
);

    localparam logic [1:0] c_WC_ALU  = 2'b00;
    localparam logic [1:0] c_WC_PC   = 2'b01;
    localparam logic [1:0] c_WC_MEM  = 2'b10;
    localparam logic [1:0] c_WC_NONE = 2'b11;

    logic [DATA_W-1:0] r_rf_q [NREGS];
    logic [DATA_W-1:0] w_rf_d [NREGS];
    logic [2:0]        r_psr_q;
    logic [2:0]        w_psr_d;
    logic [DATA_W-1:0] w_dr_in;
    logic              w_wr;
    logic              w_neg;
    logic              w_zero;

    // Write-back source select; the 11 encoding never writes, so its value
    // is irrelevant and aluout is reused to keep the mux small.
    always_comb begin
        w_dr_in = aluout;
        case (W_Control)
            c_WC_ALU: w_dr_in = aluout;
            c_WC_PC:  w_dr_in = pcout;
            c_WC_MEM: w_dr_in = memout;
            default:  w_dr_in = aluout;
        endcase
    end

    assign w_wr   = enable_writeback && (W_Control != c_WC_NONE);
    assign w_neg  = w_dr_in[DATA_W-1];
    assign w_zero = (w_dr_in == '0);

    always_comb begin
        w_rf_d  = r_rf_q;
        w_psr_d = r_psr_q;
        if (w_wr) begin
            w_rf_d[dr] = w_dr_in;
            // Exactly one of N/Z/P is set for any written value.
            w_psr_d    = {w_neg, w_zero, !w_neg && !w_zero};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf_q[i] <= '0;
            end
            r_psr_q <= 3'b000;
        end else begin
            r_rf_q  <= w_rf_d;
            r_psr_q <= w_psr_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Write-through: a read of the register being written this cycle sees
    // the incoming value, closing the write-back -> operand-read hazard.
    assign VSR1 = (w_wr && (sr1 == dr)) ? w_dr_in : r_rf_q[sr1];
    assign VSR2 = (w_wr && (sr2 == dr)) ? w_dr_in : r_rf_q[sr2];
`else
    // Reads always return stored contents; a same-cycle write shows up
    // one cycle later.
    assign VSR1 = r_rf_q[sr1];
    assign VSR2 = r_rf_q[sr2];
`endif

    assign psr = r_psr_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Self-checking bench for writeback_regfile. Expected register and
//            condition-code values are queued when a write is driven and
//            popped when the DUT result is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clock;
    logic        reset;
    logic        enable_writeback;
    logic [1:0]  W_Control;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] memout;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic [2:0]  psr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_q [$];
    logic [2:0]  psr_q [$];

    logic [15:0] e_val;
    logic [2:0]  e_psr;

    writeback_regfile #(
        .DATA_W (16),
        .NREGS  (8)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .enable_writeback (enable_writeback),
        .W_Control        (W_Control),
        .aluout           (aluout),
        .pcout            (pcout),
        .memout           (memout),
        .dr               (dr),
        .sr1              (sr1),
        .sr2              (sr2),
        .VSR1             (VSR1),
        .VSR2             (VSR2),
        .psr              (psr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Condition codes for a written value.
    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v == 16'h0000)  return 3'b010;
        else if (v[15])     return 3'b100;
        else                return 3'b001;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] wc,
                         input logic [15:0] alu, input logic [15:0] pc,
                         input logic [15:0] mem, input logic [2:0] d);
        enable_writeback = en;
        W_Control        = wc;
        aluout           = alu;
        pcout            = pc;
        memout           = mem;
        dr               = d;
    endtask

    task automatic idle();
        drive(1'b0, 2'b11, 16'h0, 16'h0, 16'h0, 3'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i);
            sr2 = 3'(7 - i);
            #1;
            e_val = exp_q.pop_front();
            n_cmp++;
            if (VSR1 !== e_val) begin
                n_bad++;
                $display("FAIL reset_vsr1[%0d]: got %h expected %h", i, VSR1, e_val);
            end
            n_cmp++;
            if (VSR2 !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_vsr2[%0d]: got %h expected 0000", 7 - i, VSR2);
            end
        end
        n_cmp++;
        if (psr !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_psr: got %b expected 000", psr);
        end
    endtask

    task automatic test_alu_write();
        drive(1'b1, 2'b00, 16'h8001, 16'h1111, 16'h2222, 3'd3);
        exp_q.push_back(16'h8001);
        psr_q.push_back(3'b100);
        tick();
        idle();
        sr1 = 3'd3;
        #1;
        e_val = exp_q.pop_front();
        e_psr = psr_q.pop_front();
        n_cmp++;
        if (VSR1 !== e_val) begin
            n_bad++;
            $display("FAIL alu_write_r3: got %h expected %h", VSR1, e_val);
        end
        n_cmp++;
        if (psr !== e_psr) begin
            n_bad++;
            $display("FAIL alu_write_psr: got %b expected %b", psr, e_psr);
        end
    endtask

    task automatic test_mem_pc();
        // Preload R5 non-zero so the zero load below is observable.
        drive(1'b1, 2'b00, 16'h7777, 16'h0, 16'h0, 3'd5);
        tick();
        drive(1'b1, 2'b10, 16'hAAAA, 16'hBBBB, 16'h0000, 3'd5);
        exp_q.push_back(16'h0000);
        psr_q.push_back(3'b010);
        tick();
        sr1 = 3'd5;
        drive(1'b1, 2'b01, 16'hAAAA, 16'h3005, 16'hCCCC, 3'd6);
        #1;
        e_val = exp_q.pop_front();
        e_psr = psr_q.pop_front();
        n_cmp++;
        if (VSR1 !== e_val) begin
            n_bad++;
            $display("FAIL mem_write_r5: got %h expected %h", VSR1, e_val);
        end
        n_cmp++;
        if (psr !== e_psr) begin
            n_bad++;
            $display("FAIL mem_write_psr: got %b expected %b", psr, e_psr);
        end
        exp_q.push_back(16'h3005);
        psr_q.push_back(3'b001);
        tick();
        idle();
        sr2 = 3'd6;
        #1;
        e_val = exp_q.pop_front();
        e_psr = psr_q.pop_front();
        n_cmp++;
        if (VSR2 !== e_val) begin
            n_bad++;
            $display("FAIL pc_write_r6: got %h expected %h", VSR2, e_val);
        end
        n_cmp++;
        if (psr !== e_psr) begin
            n_bad++;
            $display("FAIL pc_write_psr: got %b expected %b", psr, e_psr);
        end
        n_cmp++;
        if (VSR1 !== 16'h0000) begin
            n_bad++;
            $display("FAIL r5_kept: got %h expected 0000", VSR1);
        end
    endtask

    task automatic test_no_write();
        // R3 = 8001, psr = 001 from earlier tests.
        sr1 = 3'd3;
        drive(1'b1, 2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd3);
        tick();
        n_cmp++;
        if (VSR1 !== 16'h8001) begin
            n_bad++;
            $display("FAIL wc11_r3: got %h expected 8001", VSR1);
        end
        n_cmp++;
        if (psr !== 3'b001) begin
            n_bad++;
            $display("FAIL wc11_psr: got %b expected 001", psr);
        end
        drive(1'b0, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd3);
        tick();
        n_cmp++;
        if (VSR1 !== 16'h8001) begin
            n_bad++;
            $display("FAIL en0_r3: got %h expected 8001", VSR1);
        end
        n_cmp++;
        if (psr !== 3'b001) begin
            n_bad++;
            $display("FAIL en0_psr: got %b expected 001", psr);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        logic [15:0] same_exp;
        drive(1'b1, 2'b00, 16'h0F0F, 16'h0, 16'h0, 3'd2);
        tick();
        sr1 = 3'd2;
        sr2 = 3'd2;
        drive(1'b1, 2'b00, 16'h1234, 16'h0, 16'h0, 3'd2);
        #1;
`ifdef WB_BYPASS_EN
        same_exp = 16'h1234;
`else
        same_exp = 16'h0F0F;
`endif
        n_cmp++;
        if (VSR1 !== same_exp) begin
            n_bad++;
            $display("FAIL same_cycle_vsr1: got %h expected %h", VSR1, same_exp);
        end
        n_cmp++;
        if (VSR2 !== same_exp) begin
            n_bad++;
            $display("FAIL same_cycle_vsr2: got %h expected %h", VSR2, same_exp);
        end
        tick();
        // No write this cycle (W_Control=11): no forwarding in either build.
        drive(1'b1, 2'b11, 16'h5555, 16'h0, 16'h0, 3'd2);
        #1;
        n_cmp++;
        if (VSR1 !== 16'h1234) begin
            n_bad++;
            $display("FAIL next_cycle_vsr1: got %h expected 1234", VSR1);
        end
        n_cmp++;
        if (VSR2 !== 16'h1234) begin
            n_bad++;
            $display("FAIL next_cycle_vsr2: got %h expected 1234", VSR2);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [2:0]  last_cc;
        last_cc = 3'b000;
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            if (i == 4) v = 16'h0000;
            if (i == 5) v = 16'h8000;
            drive(1'b1, 2'(i % 3), v, v, v, 3'(i));
            exp_q.push_back(v);
            last_cc = cc_of(v);
            tick();
        end
        idle();
        psr_q.push_back(last_cc);
        #1;
        e_psr = psr_q.pop_front();
        n_cmp++;
        if (psr !== e_psr) begin
            n_bad++;
            $display("FAIL b2b_psr: got %b expected %b", psr, e_psr);
        end
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i);
            sr2 = 3'(i);
            #1;
            e_val = exp_q.pop_front();
            n_cmp++;
            if (VSR1 !== e_val || VSR2 !== e_val) begin
                n_bad++;
                $display("FAIL b2b_r%0d: got %h/%h expected %h", i, VSR1, VSR2, e_val);
            end
        end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 2'b00, 16'h00AA, 16'h0, 16'h0, 3'd7);
        tick();
        sr1 = 3'd7;
        idle();
        #1;
        n_cmp++;
        if (VSR1 !== 16'h00AA) begin
            n_bad++;
            $display("FAIL pre_abort_r7: got %h expected 00aa", VSR1);
        end
        reset = 1'b1;
        drive(1'b1, 2'b00, 16'h5555, 16'h0, 16'h0, 3'd7);
        tick();
        reset = 1'b0;
        idle();
        #1;
        n_cmp++;
        if (VSR1 !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort_r7: got %h expected 0000", VSR1);
        end
        n_cmp++;
        if (psr !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_psr: got %b expected 000", psr);
        end
    endtask

    initial begin
        reset = 1'b1;
        sr1   = 3'd0;
        sr2   = 3'd0;
        idle();
        tick();
        tick();
        test_reset();
        test_alu_write();
        test_mem_pc();
        test_no_write();
        test_same_cycle();
        test_back_to_back();
        test_reset_abort();
        n_cmp++;
        if (exp_q.size() != 0 || psr_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0",
                     exp_q.size(), psr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Final pipeline stage of the LC-3 core, directly downstream of the execute stage.
- Consumes execute results (aluout, pcout), the memory stage result (memout), W_Control and dr.
- Selects the write-back value, writes the 8x16 register file, and updates the 3-bit PSR condition codes.
- Serves combinational register reads (VSR1/VSR2) for the sr1/sr2 indices that execute drives.

Parameters:
- DATA_W, 16, register and datapath width.
- NREGS, 8, number of architectural registers; index width is 3 bits.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- enable_writeback  input  1  stage enable from the pipeline controller; no state changes when low.
- W_Control  input  2  write-back source select: 00 aluout, 01 pcout, 10 memout, 11 no write.
- aluout  input  16  ALU result from execute.
- pcout  input  16  address result from execute (LEA).
- memout  input  16  load data from memory stage.
- dr  input  3  destination register index.
- sr1  input  3  read port 1 index.
- sr2  input  3  read port 2 index.
- VSR1  output  16  contents of register sr1.
- VSR2  output  16  contents of register sr2.
- psr  output  3  condition codes {N,Z,P}.

Behaviour:
- Reset: synchronous, active-high; the clock port is named clock and the reset port is named reset.
  - On posedge clock with reset=1: all 8 registers <= 16'h0000 and psr <= 3'b000.
  - Reset has priority over enable_writeback.
  - VSR1/VSR2 therefore read 0 in the cycle after reset.
- Write-back value DR_in (combinational):
  - W_Control=00 -> aluout; 01 -> pcout; 10 -> memout; 11 -> don't care.
- Write qualifier: wr = enable_writeback && (W_Control != 2'b11).
- On posedge clock, reset=0, wr=1:
  - RF[dr] <= DR_in.
  - psr <= {DR_in[15], DR_in==0, !DR_in[15] && DR_in!=0}; exactly one bit set.
- On posedge clock, reset=0, wr=0: RF and psr hold.
  - Covers enable low, and W_Control=11 used for stores and branches.
- Latency:
  - Write visible on VSR1/VSR2 one cycle after the write edge.
  - psr updates at the same edge as the register write.
- Reads: VSR1 = RF[sr1], VSR2 = RF[sr2], purely combinational and independent of enable_writeback.
  - sr1 == sr2 is legal; both ports return the same value.
- Simultaneous read/write of the same register:
  - Without the optional feature, reads return the old value during the write cycle.
- No overflow or width extension; all values are exactly 16 bits.
- Reset asserted mid-stream aborts any pending write at that edge; the register keeps reset value 0.
- R0 is a normal writable register (no hardwired zero).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - In a cycle with wr=1 and sr1==dr, VSR1 = DR_in (write-through forwarding); likewise VSR2 when sr2==dr.
  - With wr=0, there is no forwarding.
  - Removes the one-cycle RAW hazard between write-back and execute operand read.
- Undefined:
  - Reads always return stored RF contents.
  - Same-cycle reads see the pre-write value.

Test Plan:
- Reset, then sr1=0..7 sweep -> VSR1=16'h0000 for every index, psr=3'b000.
- enable_writeback=1, W_Control=00, aluout=16'h8001, dr=3 -> next cycle sr1=3 gives VSR1=16'h8001, psr=3'b100.
- W_Control=10, memout=16'h0000, dr=5; then W_Control=01, pcout=16'h3005, dr=6 -> R5=0 with psr=3'b010 after the first edge; R6=16'h3005 with psr=3'b001 after the second.
- W_Control=11 with aluout=16'hFFFF, dr=3; then enable_writeback=0 with W_Control=00, dr=3 -> R3 and psr unchanged after each edge.
- Write dr=2, aluout=16'h1234 with sr1=2, sr2=2 in the same cycle -> VSR1=VSR2=old R2 without WB_BYPASS_EN; 16'h1234 combinationally with it; 16'h1234 next cycle in both builds.
- Write R7=16'h00AA, then assert reset together with a write of R7=16'h5555 -> after the edge R7=0 and psr=3'b000.
